gal_fuse_programmer: RTL and testbench
======================================

# gal_fuse_programmer

Sequencer that writes a compiled GAL fuse map (AND-array rows, OLMC configuration rows) into a physical GAL16V8/22V10-class device through its programming pins. A host streams rows over a valid/ready interface. The block serialises each row onto SDIN/SCLK, drives the row address, and generates the program or erase strobe with programmable setup and pulse widths. It sits between the JEDEC fuse buffer and the device socket pin drivers.

## Interface
Parameters:
- `ROW_BITS`, 64: fuse bits per row shifted per program cycle.
- `ADDR_BITS`, 6: width of row address (RA pins).
- `DIV`, 4: system cycles per SCLK half-period, ≥1.
- `SETUP_CYCLES`, 8: address/data setup and hold around strobe, ≥1.
- `PULSE_CYCLES`, 1000: program strobe width, ≥1.
- `ERASE_CYCLES`, 10000: bulk-erase strobe width, ≥1.

Ports:
- `C`  in  1  clock.
- `R_N`  in  1  reset, asynchronous, active-low.
- `row_valid`  in  1  row offered.
- `row_ready`  out  1  row accepted when high with `row_valid`.
- `row_addr`  in  ADDR_BITS  target row.
- `row_data`  in  ROW_BITS  fuse bits, bit 0 shifted first.
- `erase_req`  in  1  level request for bulk erase.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse at end of each row or erase.
- `SDIN`  out  1  serial fuse data.
- `SCLK`  out  1  serial shift clock.
- `STB`  out  1  strobe, active-low.
- `PV`  out  1  program (1) / verify (0) select.
- `RA`  out  ADDR_BITS  row address pins.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, SETUP, PULSE, HOLD.
- IDLE: `row_ready` = 1 only when `erase_req` = 0, so erase has priority. `busy` = 0 and `PV` = 0.
- Erase accept: `erase_req` in IDLE latches `RA` = `ERASE_ADDR` and sets `PV` = 1. Next state is SETUP, and the shift phase is skipped.
- Row accept: `row_valid && row_ready` latches `row_data` into the shift register and `row_addr` into `RA`, sets `PV` = 1, and moves to SHIFT_LO with bit index 0.
- SHIFT_LO:
  - `SCLK` = 0 and `SDIN` = current bit, held for DIV cycles.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - `SCLK` = 1 for DIV cycles, then the register shifts right.
  - After bit ROW_BITS-1, go to SETUP; otherwise go to SHIFT_LO.
  - `SDIN` never changes while `SCLK` = 1.
- SETUP: `SCLK` = 0 and `STB` = 1 for SETUP_CYCLES, then go to PULSE.
- PULSE: `STB` = 0 for PULSE_CYCLES (row) or ERASE_CYCLES (erase), then go to HOLD.
- HOLD:
  - `STB` = 1 for SETUP_CYCLES, with `RA` and `PV` still held.
  - Then return to IDLE, `done` = 1 for that one cycle, `PV` returns to 0.
- `RA` and `PV` are stable from accept through the end of HOLD.
- `erase_req` or `row_valid` changes during an operation are ignored. A level request still high in IDLE starts a new operation.

## Timing
- Reset values, applied asynchronously while `R_N` = 0:
  - `SCLK` = 0, `SDIN` = 0, `STB` = 1, `PV` = 0, `RA` = 0.
  - `busy` = 0, `done` = 0, state IDLE, counters 0.
- Reset mid-operation aborts at once. The pins reach their safe values immediately, and no `done` is issued.
- Row latency, accept edge to `done` cycle: 2·DIV·ROW_BITS + 2·SETUP_CYCLES + PULSE_CYCLES cycles.
- Erase latency: 2·SETUP_CYCLES + ERASE_CYCLES cycles.
- Back-to-back: `row_ready` rises in the `done` cycle. A row accepted in that cycle starts SHIFT_LO on the next edge.
- Cycle counter: a single down-counter, 16 bits wide. Loaded with (N−1) on state entry; the state exits when it reaches 0.
- All outputs are registered; none is combinational from inputs, except `row_ready`, which decodes state and `erase_req`.

## Structure
- Package `gal_prog_pkg` holds:
  - the state enum `gal_prog_state_t`;
  - `ERASE_ADDR` = 63;
  - `GAL16V8_ROW_BITS` = 64;
  - `CNT_W` = 16.
- Sub-module `gal_prog_timer`: a loadable down-counter with a `zero` flag, shared by all timed states.
- The shift register and bit index stay in the top level.

## Test plan
Bench parameters: ROW_BITS = 4, DIV = 1, SETUP_CYCLES = 2, PULSE_CYCLES = 3, ERASE_CYCLES = 5.

- Reset → all outputs hold their reset values. Release `R_N` → `row_ready` = 1 on the next cycle.
- Row 5, data 4'b1011:
  - SDIN sequence 1,1,0,1 is sampled on SCLK rising edges.
  - `RA` = 5 and `PV` = 1 throughout.
  - `STB` is low for exactly 3 cycles.
  - `done` arrives 15 cycles after accept.
- `erase_req` and `row_valid` asserted together:
  - erase runs first, with `RA` = 63, STB low 5 cycles, `done` after 9 cycles;
  - the row is accepted only after `erase_req` drops.
- Two rows back-to-back, `row_valid` held high:
  - second accept happens in the first row's `done` cycle;
  - no idle gap on `SCLK` beyond one cycle.
- `R_N` pulled low during PULSE:
  - `STB` returns to 1 and `PV` to 0 asynchronously;
  - no `done` is issued;
  - a fresh row then completes normally.
- `row_valid` toggled and `row_data` changed mid-shift → shifted bits match the latched value.

Source files
------------

// File: rtl/gal_prog_pkg.sv
// rtl/gal_prog_pkg.sv - shared types and constants for the GAL fuse programmer
package gal_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } gal_prog_state_t;

  localparam int ERASE_ADDR       = 63;
  localparam int GAL16V8_ROW_BITS = 64;
  localparam int CNT_W            = 16;

endpackage

// File: rtl/gal_prog_timer.sv
// rtl/gal_prog_timer.sv - loadable down-counter shared by every timed programming state
module gal_prog_timer
  import gal_prog_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gal_fuse_programmer.sv
// rtl/gal_fuse_programmer.sv - serialises fuse rows onto SDIN/SCLK and strobes program/erase pulses
module gal_fuse_programmer
  import gal_prog_pkg::*;
#(
  parameter int ROW_BITS     = GAL16V8_ROW_BITS,
  parameter int ADDR_BITS    = 6,
  parameter int DIV          = 4,
  parameter int SETUP_CYCLES = 8,
  parameter int PULSE_CYCLES = 1000,
  parameter int ERASE_CYCLES = 10000
) (
  input  logic                 C,
  input  logic                 R_N,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [ADDR_BITS-1:0] row_addr,
  input  logic [ROW_BITS-1:0]  row_data,
  input  logic                 erase_req,
  output logic                 busy,
  output logic                 done,
  output logic                 SDIN,
  output logic                 SCLK,
  output logic                 STB,
  output logic                 PV,
  output logic [ADDR_BITS-1:0] RA
);

  localparam int IDX_W = (ROW_BITS > 1) ? $clog2(ROW_BITS) : 1;

  gal_prog_state_t      state, state_n;
  logic [ROW_BITS-1:0]  shreg, shreg_n;
  logic [IDX_W-1:0]     bit_idx, bit_n;
  logic [ADDR_BITS-1:0] ra_n;
  logic                 is_erase, is_erase_n;
  logic                 sdin_n;
  logic                 done_n;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_zero;

  gal_prog_timer u_timer (
    .clk      (C),
    .rst_n    (R_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign row_ready = (state == ST_IDLE) && !erase_req;

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      is_erase <= 1'b0;
      SDIN     <= 1'b0;
      SCLK     <= 1'b0;
      STB      <= 1'b1;
      PV       <= 1'b0;
      RA       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_n;
      is_erase <= is_erase_n;
      SDIN     <= sdin_n;
      // Pins are decoded from the next state so they change together with it.
      SCLK     <= (state_n == ST_SHIFT_HI);
      STB      <= (state_n != ST_PULSE);
      PV       <= (state_n != ST_IDLE);
      RA       <= ra_n;
      busy     <= (state_n != ST_IDLE);
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_n      = bit_idx;
    ra_n       = RA;
    is_erase_n = is_erase;
    done_n     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state)
      ST_IDLE: begin
        if (erase_req) begin
          state_n    = ST_SETUP;
          ra_n       = ADDR_BITS'(ERASE_ADDR);
          is_erase_n = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(SETUP_CYCLES - 1);
        end else if (row_valid) begin
          state_n    = ST_SHIFT_LO;
          shreg_n    = row_data;
          ra_n       = row_addr;
          bit_n      = '0;
          is_erase_n = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(DIV - 1);
        end
      end
      ST_SHIFT_LO: begin
        if (tmr_zero) begin
          state_n  = ST_SHIFT_HI;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DIV - 1);
        end
      end
      ST_SHIFT_HI: begin
        if (tmr_zero) begin
          shreg_n  = shreg >> 1;
          tmr_load = 1'b1;
          if (bit_idx == IDX_W'(ROW_BITS - 1)) begin
            state_n = ST_SETUP;
            tmr_val = CNT_W'(SETUP_CYCLES - 1);
          end else begin
            state_n = ST_SHIFT_LO;
            bit_n   = bit_idx + IDX_W'(1);
            tmr_val = CNT_W'(DIV - 1);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_n  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = is_erase ? CNT_W'(ERASE_CYCLES - 1) : CNT_W'(PULSE_CYCLES - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_n  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // SDIN only moves on entry to a low clock phase, so it is stable under SCLK high.
    sdin_n = (state_n == ST_SHIFT_LO && state != ST_SHIFT_LO) ? shreg_n[0] : SDIN;
  end

endmodule

// File: tb/tb_gal_fuse_programmer.sv
// tb/tb_gal_fuse_programmer.sv - randomized self-checking bench for gal_fuse_programmer
module tb_gal_fuse_programmer;

  localparam int RB = 4;
  localparam int AB = 6;
  localparam int DV = 1;
  localparam int SU = 2;
  localparam int PW = 3;
  localparam int EW = 5;

  logic          C = 1'b0;
  logic          R_N;
  logic          row_valid, row_ready, erase_req, busy, done;
  logic [AB-1:0] row_addr, RA;
  logic [RB-1:0] row_data;
  logic          SDIN, SCLK, STB, PV;

  int n_checks = 0;
  int n_fail   = 0;

  gal_fuse_programmer #(
    .ROW_BITS(RB), .ADDR_BITS(AB), .DIV(DV),
    .SETUP_CYCLES(SU), .PULSE_CYCLES(PW), .ERASE_CYCLES(EW)
  ) dut (
    .C(C), .R_N(R_N), .row_valid(row_valid), .row_ready(row_ready),
    .row_addr(row_addr), .row_data(row_data), .erase_req(erase_req),
    .busy(busy), .done(done), .SDIN(SDIN), .SCLK(SCLK), .STB(STB),
    .PV(PV), .RA(RA)
  );

  always #5 C = ~C;

  // Follows one operation from the cycle after its accept edge up to its done cycle.
  task automatic observe(input logic [AB-1:0] addr, input logic [RB-1:0] data,
                         input bit is_erase, input bit junk, output int first_rise);
    int   exp_lat, lat, stb_low, bad_ra, bad_pv;
    bit   seen, prev;
    logic got[$];
    exp_lat    = is_erase ? (2 * SU + EW) : (2 * DV * RB + 2 * SU + PW);
    lat        = -1;
    stb_low    = 0;
    bad_ra     = 0;
    bad_pv     = 0;
    seen       = 0;
    prev       = 0;
    first_rise = -1;
    for (int n = 0; n < 200; n++) begin
      if (done === 1'b1) begin
        seen = 1;
        lat  = n;
        break;
      end
      if (RA !== addr) bad_ra++;
      if (PV !== 1'b1) bad_pv++;
      if (STB === 1'b0) stb_low++;
      if (SCLK === 1'b1 && !prev) begin
        got.push_back(SDIN);
        if (first_rise < 0) first_rise = n;
      end
      prev = (SCLK === 1'b1);
      if (junk) begin
        if (n < 10) begin
          row_valid = 1'($urandom);
          row_data  = RB'($urandom);
          row_addr  = AB'($urandom);
        end else begin
          row_valid = 1'b0;
        end
      end
      @(negedge C);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: no done within 200 cycles (erase=%0b)", is_erase);
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, expected %0d (erase=%0b)", lat, exp_lat, is_erase);
    end
    n_checks++;
    if (stb_low !== (is_erase ? EW : PW)) begin
      n_fail++;
      $display("FAIL stb_width: got %0d, expected %0d", stb_low, is_erase ? EW : PW);
    end
    n_checks++;
    if (bad_ra !== 0) begin
      n_fail++;
      $display("FAIL ra_hold: %0d cycles with RA != %0d", bad_ra, addr);
    end
    n_checks++;
    if (bad_pv !== 0) begin
      n_fail++;
      $display("FAIL pv_hold: %0d cycles with PV != 1", bad_pv);
    end
    n_checks++;
    if (got.size() !== (is_erase ? 0 : RB)) begin
      n_fail++;
      $display("FAIL sclk_count: got %0d rises, expected %0d", got.size(), is_erase ? 0 : RB);
    end else if (!is_erase) begin
      for (int i = 0; i < RB; i++) begin
        n_checks++;
        if (got[i] !== data[i]) begin
          n_fail++;
          $display("FAIL sdin_bit%0d: got %b, expected %b", i, got[i], data[i]);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if ({done, busy, PV, STB, SCLK} !== 5'b00010) begin
      n_fail++;
      $display("FAIL %s: done,busy,PV,STB,SCLK = %b, expected 00010", tag, {done, busy, PV, STB, SCLK});
    end
  endtask

  task automatic test_reset;
    R_N       = 1'b0;
    row_valid = 1'b0;
    erase_req = 1'b0;
    row_addr  = '0;
    row_data  = '0;
    repeat (2) @(negedge C);
    n_checks++;
    if ({SCLK, SDIN, STB, PV, RA, busy, done} !== {1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: SCLK=%b SDIN=%b STB=%b PV=%b RA=%0d busy=%b done=%b",
               SCLK, SDIN, STB, PV, RA, busy, done);
    end
    R_N = 1'b1;
    @(negedge C);
    n_checks++;
    if (row_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, expected 1", row_ready);
    end
  endtask

  task automatic test_row_basic;
    int fr;
    row_valid = 1'b1;
    row_addr  = 6'd5;
    row_data  = 4'b1011;
    n_checks++;
    if (row_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b, expected 1", row_ready);
    end
    @(negedge C);
    row_valid = 1'b0;
    observe(6'd5, 4'b1011, 1'b0, 1'b0, fr);
    @(negedge C);
    check_idle("basic_after_done");
  endtask

  task automatic test_erase_priority;
    int            fr;
    logic [AB-1:0] a;
    logic [RB-1:0] d;
    a         = AB'($urandom_range(0, 62));
    d         = RB'($urandom);
    erase_req = 1'b1;
    row_valid = 1'b1;
    row_addr  = a;
    row_data  = d;
    #1;
    n_checks++;
    if (row_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL erase_blocks_ready: got %b, expected 0", row_ready);
    end
    @(negedge C);
    erase_req = 1'b0;
    observe(6'd63, '0, 1'b1, 1'b0, fr);
    n_checks++;
    if (row_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_in_erase_done: got %b, expected 1", row_ready);
    end
    @(negedge C);
    observe(a, d, 1'b0, 1'b1, fr);
    @(negedge C);
    check_idle("erase_row_after_done");
  endtask

  task automatic test_back_to_back;
    int            fr;
    logic [AB-1:0] a0, a1;
    logic [RB-1:0] d0, d1;
    a0        = AB'($urandom);
    d0        = RB'($urandom);
    a1        = AB'($urandom);
    d1        = RB'($urandom);
    row_valid = 1'b1;
    row_addr  = a0;
    row_data  = d0;
    @(negedge C);
    row_addr = a1;
    row_data = d1;
    observe(a0, d0, 1'b0, 1'b0, fr);
    n_checks++;
    if (row_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_in_done: got %b, expected 1", row_ready);
    end
    @(negedge C);
    observe(a1, d1, 1'b0, 1'b1, fr);
    n_checks++;
    if (fr !== 1) begin
      n_fail++;
      $display("FAIL b2b_sclk_gap: first SCLK rise at cycle %0d, expected 1", fr);
    end
    @(negedge C);
    check_idle("b2b_after_done");
  endtask

  task automatic test_reset_in_pulse;
    int            fr, dones;
    bit            hit;
    logic [AB-1:0] a;
    logic [RB-1:0] d;
    row_valid = 1'b1;
    row_addr  = AB'($urandom);
    row_data  = RB'($urandom);
    @(negedge C);
    row_valid = 1'b0;
    hit = 0;
    for (int n = 0; n < 50; n++) begin
      if (STB === 1'b0) begin
        hit = 1;
        break;
      end
      @(negedge C);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL pulse_timeout: STB never went low");
    end
    #2 R_N = 1'b0;
    #1;
    n_checks++;
    if ({STB, PV, SCLK, busy, RA} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) begin
      n_fail++;
      $display("FAIL async_abort: STB=%b PV=%b SCLK=%b busy=%b RA=%0d, expected 1 0 0 0 0",
               STB, PV, SCLK, busy, RA);
    end
    @(negedge C);
    R_N   = 1'b1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge C);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d done/busy cycles, expected 0", dones);
    end
    a         = AB'($urandom);
    d         = RB'($urandom);
    row_valid = 1'b1;
    row_addr  = a;
    row_data  = d;
    @(negedge C);
    observe(a, d, 1'b0, 1'b1, fr);
    @(negedge C);
    check_idle("fresh_row_after_abort");
  endtask

  task automatic test_random_rows;
    int            fr;
    logic [AB-1:0] a;
    logic [RB-1:0] d;
    for (int k = 0; k < 4; k++) begin
      a         = AB'($urandom);
      d         = RB'($urandom);
      row_valid = 1'b1;
      row_addr  = a;
      row_data  = d;
      @(negedge C);
      observe(a, d, 1'b0, 1'b1, fr);
      @(negedge C);
      check_idle("random_after_done");
    end
  endtask

  initial begin
    test_reset();
    test_row_basic();
    test_erase_priority();
    test_back_to_back();
    test_reset_in_pulse();
    test_random_rows();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
